// File: rtl/mult_add_arbiter.sv
// Round-robin front end that shares one mult_add datapath among N_REQ requesters.
// An in-order tag FIFO routes each returning result back to the requester that issued it.
module mult_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int W_IN  = 8,
  parameter int W_OUT = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_val,
  input  logic [N_REQ*W_IN-1:0]   req_a,
  input  logic [N_REQ*W_IN-1:0]   req_b,
  input  logic [N_REQ*W_IN-1:0]   req_c,
  output logic [N_REQ-1:0]        req_rdy,
  output logic [W_IN-1:0]         mac_a,
  output logic [W_IN-1:0]         mac_b,
  output logic [W_IN-1:0]         mac_c,
  output logic                    mac_val_in,
  input  logic [W_OUT-1:0]        mac_s,
  input  logic                    mac_rdy_out,
  output logic [N_REQ-1:0]        res_val,
  output logic [W_OUT-1:0]        res_s,
  output logic                    busy,
  output logic                    err_orphan
);
  localparam int TW = $clog2(N_REQ);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [TW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]    tag_mem [DEPTH];
  logic [W_IN-1:0]  mac_a_q, mac_a_d;
  logic [W_IN-1:0]  mac_b_q, mac_b_d;
  logic [W_IN-1:0]  mac_c_q, mac_c_d;
  logic             mac_val_in_q, mac_val_in_d;
  logic [N_REQ-1:0] res_val_q, res_val_d;
  logic [W_OUT-1:0] res_s_q, res_s_d;
  logic             err_orphan_q, err_orphan_d;

  logic             issue_ok;
  logic             found;
  logic             pop;
  logic [TW-1:0]    cand;
  logic [TW-1:0]    grant_idx;
  logic [N_REQ-1:0] grant;

  // Grant scan starts at ptr; holding reset also suppresses any grant.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    issue_ok  = rst_n && (count_q < CW'(DEPTH));
    found     = 1'b0;
    cand      = '0;
    grant_idx = '0;
    grant     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = TW'((int'(ptr_q) + k) % N_REQ);
      if (issue_ok && !found && req_val[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign pop = mac_rdy_out && (count_q != '0);

  always_comb begin
    ptr_d        = ptr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mac_a_d      = mac_a_q;
    mac_b_d      = mac_b_q;
    mac_c_d      = mac_c_q;
    mac_val_in_d = found;
    res_val_d    = '0;
    res_s_d      = res_s_q;
    err_orphan_d = err_orphan_q | (mac_rdy_out && (count_q == '0));

    if (found) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (grant_idx == TW'(k)) begin
          mac_a_d = req_a[k*W_IN +: W_IN];
          mac_b_d = req_b[k*W_IN +: W_IN];
          mac_c_d = req_c[k*W_IN +: W_IN];
        end
      end
      ptr_d    = (grant_idx == TW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end

    if (pop) begin
      res_val_d[tag_mem[rd_ptr_q]] = 1'b1;
      res_s_d  = mac_s;
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({found, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_c_q      <= '0;
      mac_val_in_q <= 1'b0;
      res_val_q    <= '0;
      res_s_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
      mac_c_q      <= mac_c_d;
      mac_val_in_q <= mac_val_in_d;
      res_val_q    <= res_val_d;
      res_s_q      <= res_s_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // NOTE: tag storage has no reset; an entry is only read after being written, as count_q guards it.
  always_ff @(posedge clk) begin
    if (found) tag_mem[wr_ptr_q] <= grant_idx;
  end

  assign req_rdy    = grant;
  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_c      = mac_c_q;
  assign mac_val_in = mac_val_in_q;
  assign res_val    = res_val_q;
  assign res_s      = res_s_q;
  assign busy       = (count_q != '0);
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_mult_add_arbiter.sv
// Bench for mult_add_arbiter: a latency-2 mult_add model on the main instance, a
// queue-based scoreboard of expected results, and a DEPTH=2 instance for backpressure.
module tb_mult_add_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int WO = 16;
  localparam int D  = 4;
  localparam int D2 = 2;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]   req_val = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   mac_a, mac_b, mac_c;
  logic           mac_val_in;
  logic [WO-1:0]  mac_s;
  logic           mac_rdy_out;
  logic [N-1:0]   res_val;
  logic [WO-1:0]  res_s;
  logic           busy, err_orphan;

  logic [N-1:0]   b_req_val = '0;
  logic [N*W-1:0] b_req_a = '0, b_req_b = '0, b_req_c = '0;
  logic [N-1:0]   b_req_rdy;
  logic [W-1:0]   b_mac_a, b_mac_b, b_mac_c;
  logic           b_mac_val_in;
  logic [WO-1:0]  b_mac_s = 16'h1234;
  logic           b_mac_rdy_out = 1'b0;
  logic [N-1:0]   b_res_val;
  logic [WO-1:0]  b_res_s;
  logic           b_busy, b_err_orphan;

  mult_add_arbiter #(.N_REQ(N), .W_IN(W), .W_OUT(WO), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_rdy(req_rdy),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_val_in(mac_val_in),
    .mac_s(mac_s), .mac_rdy_out(mac_rdy_out),
    .res_val(res_val), .res_s(res_s), .busy(busy), .err_orphan(err_orphan)
  );

  mult_add_arbiter #(.N_REQ(N), .W_IN(W), .W_OUT(WO), .DEPTH(D2)) dut_bp (
    .clk(clk), .rst_n(rst_n),
    .req_val(b_req_val), .req_a(b_req_a), .req_b(b_req_b), .req_c(b_req_c), .req_rdy(b_req_rdy),
    .mac_a(b_mac_a), .mac_b(b_mac_b), .mac_c(b_mac_c), .mac_val_in(b_mac_val_in),
    .mac_s(b_mac_s), .mac_rdy_out(b_mac_rdy_out),
    .res_val(b_res_val), .res_s(b_res_s), .busy(b_busy), .err_orphan(b_err_orphan)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Fixed-latency mult_add stand-in; it ignores reset so in-flight work survives one.
  logic [L-1:0]  mv = '0;
  logic [WO-1:0] ms [L];
  always @(posedge clk) begin
    mv    <= {mv[L-2:0], mac_val_in};
    ms[0] <= WO'(int'($signed(mac_a)) * int'($signed(mac_b)) + int'($signed(mac_c)));
    for (int i = 1; i < L; i++) ms[i] <= ms[i-1];
  end
  assign mac_rdy_out = mv[L-1];
  assign mac_s       = ms[L-1];

  typedef struct {
    int            tag;
    logic [WO-1:0] val;
    int            due;
  } exp_t;

  exp_t            exp_q[$];
  int              glog[$];
  int              ptr_m = 0;
  logic            orphan_exp = 1'b0;
  logic [WO-1:0]   last_res_s = '0;
  logic signed [W-1:0] op_a [N];
  logic signed [W-1:0] op_b [N];
  logic signed [W-1:0] op_c [N];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WO-1:0] ref_mac(input int a, input int b, input int c);
    return WO'(a * b + c);
  endfunction

  // Round-robin rule: first valid requester at or after the pointer, if the FIFO has room.
  function automatic int ref_grant(input logic [N-1:0] val);
    if (!rst_n || exp_q.size() >= D) return -1;
    for (int k = 0; k < N; k++)
      if (val[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  task automatic check_results();
    logic [N-1:0] ev;
    exp_t e;
    ev = '0;
    if (exp_q.size() > 0 && exp_q[0].due == edges) begin
      e  = exp_q.pop_front();
      ev = N'(1 << e.tag);
      check("res_s", 32'(res_s), 32'(e.val));
    end
    check("res_val", 32'(res_val), 32'(ev));
    if (res_val != '0) last_res_s = res_s;
    check("busy", 32'(busy), (exp_q.size() != 0) ? 32'd1 : 32'd0);
    check("err_orphan", 32'(err_orphan), 32'(orphan_exp));
  endtask

  // One clock: drive at the negedge, check grant before the edge, check outputs at the next negedge.
  task automatic step(input logic [N-1:0] val, output int g);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_c[i*W +: W] = op_c[i];
    end
    req_val = val;
    #1;
    g = ref_grant(val);
    check("req_rdy", 32'(req_rdy), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    @(negedge clk);
    check("mac_val_in", 32'(mac_val_in), (g >= 0) ? 32'd1 : 32'd0);
    if (g >= 0) begin
      check("mac_a", 32'(mac_a), {24'd0, op_a[g]});
      check("mac_b", 32'(mac_b), {24'd0, op_b[g]});
      check("mac_c", 32'(mac_c), {24'd0, op_c[g]});
      e.tag = g;
      e.val = ref_mac(op_a[g], op_b[g], op_c[g]);
      e.due = edges + L + 1;
      exp_q.push_back(e);
      ptr_m = (g + 1) % N;
      glog.push_back(g);
    end
    check_results();
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step('0, g);
  endtask

  task automatic issue_each(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int g;
    pend = mask;
    for (int t = 0; t < 4 * N && pend != '0; t++) begin
      step(pend, g);
      if (g >= 0) pend[g] = 1'b0;
    end
    check("issue_done", 32'(pend), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    check("rst_mac_val_in", 32'(mac_val_in), 32'd0);
    check("rst_mac_a", 32'(mac_a), 32'd0);
    check("rst_mac_b", 32'(mac_b), 32'd0);
    check("rst_mac_c", 32'(mac_c), 32'd0);
    check("rst_res_val", 32'(res_val), 32'd0);
    check("rst_res_s", 32'(res_s), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_orphan", 32'(err_orphan), 32'd0);
  endtask

  task automatic reset_all();
    rst_n   = 1'b0;
    req_val = '1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n   = 1'b1;
    req_val = '0;
    exp_q.delete();
    ptr_m      = 0;
    orphan_exp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g, nb, n0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
      op_c[i] = '0;
    end

    // Reset state, with every requester asking.
    req_val = '1;
    #2;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    req_val = '0;

    // Backpressure on the DEPTH=2 instance: no results return, so only two issues fit.
    b_req_val = 4'b0001;
    b_req_a   = 32'h0000_0011;
    nb = 0;
    for (int t = 0; t < 6; t++) begin
      #1;
      if (b_req_rdy[0]) nb++;
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_issues", 32'(nb), 32'd2);
    check("bp_rdy_full", 32'(b_req_rdy), 32'd0);
    check("bp_busy", 32'(b_busy), 32'd1);
    check("bp_mac_val_idle", 32'(b_mac_val_in), 32'd0);
    b_mac_rdy_out = 1'b1;
    @(posedge clk);
    #1 b_mac_rdy_out = 1'b0;
    @(negedge clk);
    check("bp_res_val", 32'(b_res_val), 32'h1);
    check("bp_res_s", 32'(b_res_s), 32'h1234);
    check("bp_rdy_after_pop", 32'(b_req_rdy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("bp_reissue", 32'(b_mac_val_in), 32'd1);
    check("bp_rdy_full_again", 32'(b_req_rdy), 32'd0);
    check("bp_res_val_clear", 32'(b_res_val), 32'd0);
    check("bp_busy_again", 32'(b_busy), 32'd1);
    b_req_val = '0;

    // Single request from requester 1.
    op_a[1] = 8'sd3;
    op_b[1] = -8'sd4;
    op_c[1] = 8'sd5;
    last_res_s = '0;
    issue_each(4'b0010);
    idle(L + 3);
    check("single_res_s", 32'(last_res_s), 32'h0000_FFF9);

    // All four at once from a fresh pointer: grants in order 0..3.
    reset_all();
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'(i);
      op_b[i] = 8'sd2;
      op_c[i] = 8'sd1;
    end
    glog.delete();
    issue_each(4'b1111);
    check("all4_grant_cnt", 32'(glog.size()), 32'd4);
    for (int i = 0; i < glog.size(); i++) check("all4_order", 32'(glog[i]), 32'(i));
    idle(L + 3);

    // Fairness: requester 2 joins after three grants to requester 0.
    op_a[0] = 8'sd1; op_b[0] = 8'sd1; op_c[0] = 8'sd0;
    op_a[2] = 8'sd2; op_b[2] = 8'sd2; op_c[2] = 8'sd2;
    n0 = 0;
    for (int t = 0; t < 12 && n0 < 3; t++) begin
      step(4'b0001, g);
      if (g == 0) n0++;
    end
    check("fair_warmup", 32'(n0), 32'd3);
    step(4'b0101, g);
    check("fair_next_is_2", 32'(g), 32'd2);
    for (int t = 0; t < 6; t++) step(4'b0101, g);
    idle(L + 3);

    // Operand extremes.
    op_a[3] = -8'sd128; op_b[3] = -8'sd128; op_c[3] = 8'sd127;
    issue_each(4'b1000);
    idle(L + 3);
    check("ext_pos", 32'(last_res_s), 32'd16511);
    op_a[0] = 8'sd127; op_b[0] = -8'sd128; op_c[0] = -8'sd128;
    issue_each(4'b0001);
    idle(L + 3);
    check("ext_neg", 32'(last_res_s), 32'h0000_C000);

    // Randomized traffic against the scoreboard.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        op_a[i] = W'($urandom);
        op_b[i] = W'($urandom);
        op_c[i] = W'($urandom);
      end
      step(N'($urandom_range(0, (1 << N) - 1)), g);
    end
    idle(L + 3);

    // Reset mid-flight: two operations inside mult_add, reset pulsed within one cycle.
    op_a[0] = 8'sd5; op_b[0] = 8'sd6; op_c[0] = 8'sd7;
    op_a[1] = -8'sd9; op_b[1] = 8'sd3; op_c[1] = 8'sd1;
    issue_each(4'b0011);
    idle(1);
    #2 rst_n = 1'b0;
    req_val = '1;
    #1;
    check_reset_outputs();
    #1;
    req_val = '0;
    rst_n   = 1'b1;
    exp_q.delete();
    ptr_m = 0;
    @(negedge clk);
    orphan_exp = 1'b1;
    check_results();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
